// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LD/ST stage.
// Data has priority, fetch is protected by a starvation counter, and halt drains data traffic.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt,
  output logic              halted
);

  localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             if_pend_q, if_pend_d;
  logic             dm_pend_q, dm_pend_d;

  always_comb begin
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    if (!reset) begin
      case (state_q)
        RUN: begin
          if (if_req && (starve_cnt_q == CNT_MAX)) begin
            if_gnt = 1'b1;
          end else if (dm_req) begin
            dm_gnt = 1'b1;
          end else if (if_req) begin
            if_gnt = 1'b1;
          end
        end
        DRAIN:   dm_gnt = dm_req;
        default: ;
      endcase
    end

    // A store issues but owns no return slot.
    if_pend_d = if_gnt;
    dm_pend_d = dm_gnt & ~dm_we;

    case (state_q)
      RUN: begin
        if (if_req && !if_gnt) begin
          starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
        end else begin
          starve_cnt_d = '0;
        end
        if (halt) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!dm_req && !if_pend_d && !dm_pend_d) begin
          state_d = HALTED;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_addr = dm_addr;
      if (dm_we) begin
        mem_wdata = dm_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      starve_cnt_q <= '0;
      if_pend_q    <= 1'b0;
      dm_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_pend_q    <= if_pend_d;
      dm_pend_q    <= dm_pend_d;
    end
  end

  // A return already in flight when reset arrives is suppressed immediately.
  assign if_rvalid = if_pend_q & ~reset;
  assign dm_rvalid = dm_pend_q & ~reset;
  assign rdata     = mem_rdata;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset, if_req, dm_req, dm_we, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, halted;
  logic [15:0] rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halt(halt), .halted(halted)
  );

  function automatic logic [15:0] init_word(input logic [7:0] a);
    return {a, ~a} ^ 16'h1357;
  endfunction

  // Synchronous single-port memory environment (256 words, address aliased).
  logic [15:0] env_mem [0:255];
  bit          env_wr  [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr[7:0]] <= mem_wdata;
        env_wr[mem_addr[7:0]]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
      end
    end
  end

  // Reference model state: mode 0 run, 1 drain, 2 halted; ret 0 none, 1 fetch, 2 load.
  int          m_mode = 0;
  int          m_denied = 0;
  int          m_ret = 0;
  logic [15:0] m_ret_data = '0;
  logic [15:0] ref_mem [int];

  logic        e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we, e_if_rv, e_dm_rv, e_halted;
  logic [15:0] e_mem_addr, e_mem_wdata, e_rdata;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    int idx;
    idx = int'(a[7:0]);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(a[7:0]);
  endfunction

  function automatic void eval();
    e_if_gnt = 1'b0;
    e_dm_gnt = 1'b0;
    if (!reset) begin
      if (m_mode == 0) begin
        if (if_req && m_denied >= LIM) e_if_gnt = 1'b1;
        else if (dm_req)               e_dm_gnt = 1'b1;
        else if (if_req)               e_if_gnt = 1'b1;
      end else if (m_mode == 1) begin
        e_dm_gnt = dm_req;
      end
    end
    e_mem_en    = e_if_gnt | e_dm_gnt;
    e_mem_we    = e_dm_gnt & dm_we;
    e_mem_addr  = e_if_gnt ? if_addr : dm_addr;
    e_mem_wdata = dm_wdata;
    e_if_rv     = !reset && m_ret == 1;
    e_dm_rv     = !reset && m_ret == 2;
    e_rdata     = m_ret_data;
    e_halted    = (m_mode == 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_denied = 0; m_ret = 0;
    end else begin
      m_ret = 0;
      if (e_if_gnt) begin
        m_ret = 1; m_ret_data = ref_read(if_addr);
      end else if (e_dm_gnt && !dm_we) begin
        m_ret = 2; m_ret_data = ref_read(dm_addr);
      end else if (e_dm_gnt) begin
        ref_mem[int'(dm_addr[7:0])] = dm_wdata;
      end
      if (m_mode == 0) begin
        m_denied = (if_req && !e_if_gnt) ? ((m_denied < LIM) ? m_denied + 1 : LIM) : 0;
        if (halt) m_mode = 1;
      end else if (m_mode == 1 && !dm_req) begin
        m_mode = 2;
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic ir, input logic [15:0] ia,
                       input logic dr, input logic dw, input logic [15:0] da,
                       input logic [15:0] dd, input logic h);
    reset = r; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
    dm_addr = da; dm_wdata = dd; halt = h;
  endtask

  task automatic test_reset();
    drive(1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0);
    repeat (2) begin
      #4; eval();
      checks++;
      if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
        errors++; $display("FAIL reset_gnts got %b exp 000", {if_gnt, dm_gnt, mem_en});
      end
      tick();
    end
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if ({if_rvalid, dm_rvalid, halted} !== 3'b000) begin
      errors++; $display("FAIL reset_state got %b exp 000", {if_rvalid, dm_rvalid, halted});
    end
    tick();
  endtask

  task automatic test_idle_fetch();
    drive(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL idle_fetch_issue got gnt/en/we=%b addr=%h exp 1010 0010",
                         {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr);
    end
    tick();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b10) begin
      errors++; $display("FAIL idle_fetch_rvalid got %b exp 10", {if_rvalid, dm_rvalid});
    end
    checks++;
    if (rdata !== init_word(8'h10)) begin
      errors++; $display("FAIL idle_fetch_rdata got %h exp %h", rdata, init_word(8'h10));
    end
    tick();
  endtask

  task automatic test_conflict();
    drive(0, 1, 16'h0044, 1, 0, 16'h0200, 16'h0000, 0);
    #4; eval();
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b01 || mem_addr !== 16'h0200 || mem_we !== 1'b0) begin
      errors++; $display("FAIL conflict_issue got gnt=%b addr=%h we=%b exp 01 0200 0",
                         {if_gnt, dm_gnt}, mem_addr, mem_we);
    end
    tick();
    drive(0, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b01 || rdata !== e_rdata) begin
      errors++; $display("FAIL conflict_return got rv=%b rdata=%h exp 01 %h",
                         {if_rvalid, dm_rvalid}, rdata, e_rdata);
    end
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 16'h0044) begin
      errors++; $display("FAIL conflict_fetch_after got gnt=%b addr=%h exp 1 0044", if_gnt, mem_addr);
    end
    tick();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval(); tick();
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 16'h0100 + 16'(i), 1, 0, 16'h0300 + 16'(i), 16'h0000, 0);
      #4; eval();
      checks++;
      if (if_gnt !== (i % 5 == 4) || dm_gnt !== (i % 5 != 4)) begin
        errors++; $display("FAIL starve_cycle%0d got if/dm=%b%b exp %b%b", i, if_gnt, dm_gnt,
                           (i % 5 == 4), (i % 5 != 4));
      end
      checks++;
      if ({if_rvalid, dm_rvalid} !== {e_if_rv, e_dm_rv}) begin
        errors++; $display("FAIL starve_rvalid%0d got %b exp %b", i, {if_rvalid, dm_rvalid},
                           {e_if_rv, e_dm_rv});
      end
      tick();
    end
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval(); tick();
  endtask

  task automatic test_store();
    drive(0, 0, 16'h0000, 1, 1, 16'h0033, 16'hBEEF, 0);
    #4; eval();
    checks++;
    if ({dm_gnt, mem_en, mem_we} !== 3'b111 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h0033) begin
      errors++; $display("FAIL store_issue got gnt/en/we=%b addr=%h wdata=%h exp 111 0033 beef",
                         {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    drive(0, 0, 16'h0000, 1, 0, 16'h0033, 16'h0000, 0);
    #4; eval();
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00 || dm_gnt !== 1'b1) begin
      errors++; $display("FAIL store_no_return got rv=%b gnt=%b exp 00 1", {if_rvalid, dm_rvalid}, dm_gnt);
    end
    tick();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if (dm_rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
      errors++; $display("FAIL store_readback got rv=%b rdata=%h exp 1 beef", dm_rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_random();
    logic ir, dr, dw;
    logic [15:0] ia, da, dd;
    ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ir) begin ir = 1'($urandom_range(0, 1)); ia = 16'($urandom); end
      if (!dr) begin
        dr = ($urandom_range(0, 3) != 0); dw = 1'($urandom_range(0, 1));
        da = 16'($urandom); dd = 16'($urandom);
      end
      drive(0, ir, ia, dr, dw, da, dd, 0);
      #4; eval();
      checks++;
      if ({if_gnt, dm_gnt, mem_en, mem_we} !== {e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we}) begin
        errors++; $display("FAIL rand_gnt cyc%0d got %b exp %b", i, {if_gnt, dm_gnt, mem_en, mem_we},
                           {e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we});
      end
      if (e_mem_en) begin
        checks++;
        if (mem_addr !== e_mem_addr || (e_mem_we && mem_wdata !== e_mem_wdata)) begin
          errors++; $display("FAIL rand_mem cyc%0d got addr=%h wdata=%h exp %h %h", i,
                             mem_addr, mem_wdata, e_mem_addr, e_mem_wdata);
        end
      end
      checks++;
      if ({if_rvalid, dm_rvalid} !== {e_if_rv, e_dm_rv}) begin
        errors++; $display("FAIL rand_rvalid cyc%0d got %b exp %b", i, {if_rvalid, dm_rvalid},
                           {e_if_rv, e_dm_rv});
      end
      if (e_if_rv || e_dm_rv) begin
        checks++;
        if (rdata !== e_rdata) begin
          errors++; $display("FAIL rand_rdata cyc%0d got %h exp %h", i, rdata, e_rdata);
        end
      end
      tick();
      if (e_if_gnt) ir = 1'b0;
      if (e_dm_gnt) dr = 1'b0;
    end
  endtask

  task automatic test_halt_drain();
    drive(0, 1, 16'h0050, 0, 0, 16'h0000, 16'h0000, 1);
    #4; eval();
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 16'h0050) begin
      errors++; $display("FAIL halt_cycle_fetch got gnt=%b addr=%h exp 1 0050", if_gnt, mem_addr);
    end
    tick();
    drive(0, 1, 16'h0054, 1, 0, 16'h0060, 16'h0000, 0);
    #4; eval();
    checks++;
    if (if_rvalid !== 1'b1 || rdata !== e_rdata || {if_gnt, dm_gnt} !== 2'b01) begin
      errors++; $display("FAIL halt_fetch_return got rv=%b rdata=%h gnt=%b exp 1 %h 01",
                         if_rvalid, rdata, {if_gnt, dm_gnt}, e_rdata);
    end
    tick();
    drive(0, 1, 16'h0058, 1, 0, 16'h0061, 16'h0000, 0);
    #4; eval();
    checks++;
    if (dm_rvalid !== 1'b1 || {if_gnt, dm_gnt} !== 2'b01 || halted !== 1'b0) begin
      errors++; $display("FAIL drain_load2 got rv=%b gnt=%b halted=%b exp 1 01 0",
                         dm_rvalid, {if_gnt, dm_gnt}, halted);
    end
    tick();
    drive(0, 1, 16'h005C, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if (dm_rvalid !== 1'b1 || rdata !== e_rdata || if_gnt !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL drain_last_return got rv=%b rdata=%h gnt=%b halted=%b exp 1 %h 0 0",
                         dm_rvalid, rdata, if_gnt, halted, e_rdata);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 16'(16'h0070 + i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'h0080, 16'h1234, 1'($urandom_range(0, 1)));
      #4; eval();
      checks++;
      if (halted !== 1'b1 || {if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid} !== 5'b00000
          || halted !== e_halted) begin
        errors++; $display("FAIL halted_quiet%0d got halted=%b bus=%b exp 1 00000", i, halted,
                           {if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    drive(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval(); tick();
    drive(0, 0, 16'h0000, 1, 0, 16'h0070, 16'h0000, 0);
    #4; eval();
    checks++;
    if (dm_gnt !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL rst_load_issue got gnt=%b halted=%b exp 1 0", dm_gnt, halted);
    end
    tick();
    drive(1, 1, 16'h0080, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if (dm_rvalid !== 1'b0 || if_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rst_drop_rvalid got rv=%b gnt=%b en=%b exp 0 0 0", dm_rvalid, if_gnt, mem_en);
    end
    tick();
    drive(0, 1, 16'h0080, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 16'h0080 || halted !== 1'b0 || dm_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_first_fetch got gnt=%b addr=%h halted=%b rv=%b exp 1 0080 0 0",
                         if_gnt, mem_addr, halted, dm_rvalid);
    end
    tick();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    #4; eval();
    checks++;
    if (if_rvalid !== 1'b1 || rdata !== e_rdata) begin
      errors++; $display("FAIL rst_fetch_return got rv=%b rdata=%h exp 1 %h", if_rvalid, rdata, e_rdata);
    end
    tick();
  endtask

  initial begin
    drive(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    @(posedge clk); #1;
    test_reset();
    test_idle_fetch();
    test_conflict();
    test_starvation();
    test_store();
    test_random();
    test_halt_drain();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port main memory between the instruction-fetch stage and the data stage (LD/ST) of the 16-bit pipelined core. It issues at most one memory access per cycle and routes synchronous read data back to the requester that owns it. Data accesses take priority, with a starvation guard for fetch. It also sequences halt: it stops fetch, drains outstanding data traffic, then reports the core halted.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request; held until granted
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch access issued this cycle (combinational)
- if_rvalid  out  1  fetch read data valid on rdata (registered)
- dm_req  in  1  data request; held until granted
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data access issued this cycle (combinational)
- dm_rvalid  out  1  load data valid on rdata (registered)
- rdata  out  DATA_W  shared return bus, equal to mem_rdata
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read issue
- halt  in  1  single-cycle pulse from decode on the HALT instruction
- halted  out  1  core quiesced; sticky until reset

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset enters RUN.
- **RUN arbitration**, each cycle:
  - if starve_cnt == STARVE_LIMIT and if_req: fetch wins.
  - else if dm_req: data wins.
  - else if if_req: fetch wins.
  - else idle.
- Winner's gnt = 1. mem_en = 1. mem_addr, mem_we and mem_wdata come from the winner; fetch forces mem_we = 0.
- **starve_cnt** has width clog2(STARVE_LIMIT+1) and saturates at STARVE_LIMIT.
  - Increments when if_req = 1 and if_gnt = 0.
  - Clears when if_gnt = 1 or if_req = 0.
- **Owner register** is set when a read issues: IF for a fetch, DM for a load. A store records no owner.
- **Read return:** the cycle after a read issues, the owner's rvalid = 1. Both rvalid are never 1 together.
- **halt handling:**
  - A halt pulse in RUN moves the FSM to DRAIN at the next edge.
  - The fetch grant in the halt cycle itself is still allowed, and its rvalid still returns.
- **DRAIN:**
  - No fetch grants; if_req is ignored and starve_cnt is held.
  - Data requests are granted normally.
  - Moves to HALTED when no read return is pending for the next cycle and dm_req = 0.
- **HALTED:**
  - halted = 1. All gnt, mem_en and rvalid = 0.
  - Leaves only on reset. halt is ignored in DRAIN and HALTED.
- **Reset mid-operation:**
  - A pending read's rvalid is dropped.
  - starve_cnt = 0; FSM returns to RUN.

## Timing
- Reset values, in the cycle after reset is sampled: if_rvalid = dm_rvalid = 0, halted = 0, starve_cnt = 0, state = RUN.
- While reset is high, if_gnt, dm_gnt and mem_en are forced to 0.
- gnt and mem_* are combinational from the requests and registered state, with zero added latency.
- Read latency: issue in cycle N, rvalid and rdata in cycle N+1.
- Back-to-back issue every cycle is supported. A store in N+1 does not disturb the read return in N+1.
- halt sampled in cycle N: fetch grants are blocked from N+1. halted is asserted at the earliest in N+2.
- Fetch worst-case wait under continuous dm_req: STARVE_LIMIT denied cycles, then a grant in the next cycle.

## Test plan
- **Idle fetch:** if_req = 1, if_addr = 0x0010, dm_req = 0.
  - if_gnt = 1 and mem_addr = 0x0010 in the same cycle.
  - Next cycle: if_rvalid = 1 and rdata = mem_rdata.
- **Conflict:** if_req = dm_req = 1 (load 0x0200), starve_cnt = 0.
  - dm_gnt = 1 and mem_addr = 0x0200; if_gnt = 0.
  - Next cycle: dm_rvalid = 1 and if_rvalid = 0.
- **Starvation:** dm_req held high for 10 cycles with if_req high, STARVE_LIMIT = 4.
  - Cycles 0–3: dm_gnt.
  - Cycle 4: if_gnt = 1 and dm_gnt = 0.
  - Cycle 5: dm_gnt again, with starve_cnt back at 0.
- **Store:** dm_req = 1, dm_we = 1, addr 0x0033, wdata 0xBEEF.
  - mem_we = 1 and mem_wdata = 0xBEEF.
  - No rvalid in the following cycle.
- **Halt drain:** a halt pulse in the same cycle as a fetch grant, then dm_req for 2 more cycles.
  - The fetch rvalid still returns.
  - Subsequent if_req is never granted.
  - halted rises the cycle after the last data return; all grants stay 0 afterwards.
- **Reset mid-read:** reset asserted in the cycle after a load issue.
  - dm_rvalid = 0 and halted = 0.
  - The first post-reset if_req is granted immediately.
